// File: rtl/bfly_pkg.sv
// Shared definitions for the radix-2 butterfly stages: index helpers, bit reversal
// and the {im, re} packing layout used between stages.
package bfly_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } bfly_state_t;

    // Complex words are packed {im, re}, real part in the low bits.
    localparam int CPLX_RE_LSB = 0;

    function automatic int cplx_im_lsb(input int dw);
        return dw;
    endfunction

    function automatic int cplx_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] k, input int lw);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < lw; i++) begin
            r[lw-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bfly_stage1_stream_bfly2.sv
// Radix-2 W0 butterfly on packed {im, re} operands: sum = a+b, dif = a-b, one bit of growth.
module bfly2 #(
    parameter int DW = 8
) (
    input  logic [2*DW-1:0]     i_a,
    input  logic [2*DW-1:0]     i_b,
    output logic [2*(DW+1)-1:0] o_sum,
    output logic [2*(DW+1)-1:0] o_dif
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [DW:0] w_a_ext;
            logic signed [DW:0] w_b_ext;

            // Sign-extend before the add so the extra bit can never wrap.
            assign w_a_ext = {i_a[gi*DW + DW-1], i_a[gi*DW +: DW]};
            assign w_b_ext = {i_b[gi*DW + DW-1], i_b[gi*DW +: DW]};

            assign o_sum[gi*(DW+1) +: DW+1] = w_a_ext + w_b_ext;
            assign o_dif[gi*(DW+1) +: DW+1] = w_a_ext - w_b_ext;
        end
    endgenerate

endmodule

// File: rtl/bfly_stage1_stream.sv
// Streaming first DIT radix-2 stage: loads one frame into a buffer, then drains a+b / a-b pairs.
// Build option BFLY_BITREV_EN: defined = input in natural order (bit-reversed on write).
module bfly_stage1_stream
    import bfly_pkg::*;
#(
    parameter int N  = 32,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_re,
    input  logic [DW-1:0]          in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW:0]            out_re,
    output logic [DW:0]            out_im,
    output logic [idx_w(N)-1:0]    out_idx,
    output logic                   out_last
);

    localparam int LW     = idx_w(N);
    localparam int CW     = cplx_w(DW);
    localparam int IM_LSB = cplx_im_lsb(DW);

    bfly_state_t r_state;
    bfly_state_t w_state_next;

    logic [LW-1:0] r_load_cnt;
    logic [LW:0]   r_iss_cnt;
    logic [CW-1:0] r_buf [N];

    logic          r_out_valid;
    logic [DW:0]   r_out_re;
    logic [DW:0]   r_out_im;
    logic [LW-1:0] r_out_idx;
    logic          r_out_last;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_issue;
    logic          w_load_last;
    logic [LW-1:0] w_wr_slot;
    logic [LW-1:0] w_rd_a;
    logic [LW-1:0] w_rd_b;
    logic [CW-1:0] w_a;
    logic [CW-1:0] w_b;
    logic [2*(DW+1)-1:0] w_sum;
    logic [2*(DW+1)-1:0] w_dif;

    assign in_ready    = (r_state == ST_LOAD);
    assign w_in_fire   = in_valid && in_ready;
    assign w_load_last = (r_load_cnt == LW'(N-1));
    assign w_out_fire  = r_out_valid && out_ready;
    // Issue a new result when the output register is empty or being emptied this cycle.
    assign w_issue     = (r_state == ST_DRAIN) && !r_iss_cnt[LW] && (!r_out_valid || out_ready);

`ifdef BFLY_BITREV_EN
    assign w_wr_slot = LW'(bitrev(32'(r_load_cnt), LW));
`else
    assign w_wr_slot = r_load_cnt;
`endif

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[w_wr_slot] <= {in_im, in_re};
        end
    end

    assign w_rd_a = {r_iss_cnt[LW-1:1], 1'b0};
    assign w_rd_b = {r_iss_cnt[LW-1:1], 1'b1};
    assign w_a    = r_buf[w_rd_a];
    assign w_b    = r_buf[w_rd_b];

    bfly2 #(
        .DW (DW)
    ) u_bfly2 (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum),
        .o_dif (w_dif)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_in_fire && w_load_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_fire && r_out_last) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_cnt  <= '0;
            r_iss_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
            end

            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_iss_cnt[LW-1:0];
                r_out_last  <= (r_iss_cnt[LW-1:0] == LW'(N-1));
                // Even index carries a+b, odd index a-b of the same pair.
                if (r_iss_cnt[0]) begin
                    r_out_re <= w_dif[CPLX_RE_LSB +: DW+1];
                    r_out_im <= w_dif[DW+1 +: DW+1];
                end else begin
                    r_out_re <= w_sum[CPLX_RE_LSB +: DW+1];
                    r_out_im <= w_sum[DW+1 +: DW+1];
                end
                r_iss_cnt <= r_iss_cnt + 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_fire && r_out_last) begin
                r_iss_cnt   <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
